// File: rtl/dds_phase_gen.sv
// Phase-sequence generator feeding the DDS core: phase accumulator driven by a
// constant or stepped (chirp) tuning word, single-shot or continuously repeating.
module dds_phase_gen #(
  parameter int PHASE_W = 25,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      mode_i,
  input  logic        [PHASE_W-1:0] ftw_start_i,
  input  logic signed [PHASE_W-1:0] ftw_step_i,
  input  logic        [CNT_W-1:0]   sweep_len_i,
  input  logic        [CNT_W-1:0]   dwell_i,
  input  logic        [PHASE_W-1:0] phase_off_i,
  output logic        [PHASE_W-1:0] phase_o,
  output logic                      phase_valid_o,
  output logic                      busy_o,
  output logic                      sweep_done_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic                        r_mode;
  logic        [PHASE_W-1:0]   r_ftw_start;
  logic signed [PHASE_W-1:0]   r_ftw_step;
  logic        [CNT_W-1:0]     r_len;
  logic        [CNT_W-1:0]     r_dwell_m1;

  logic        [PHASE_W-1:0]   r_ftw;
  logic        [PHASE_W-1:0]   r_phase;
  logic        [CNT_W-1:0]     r_dcnt;
  logic        [CNT_W-1:0]     r_scnt;

  logic                        w_start;
  logic                        w_seg_end;
  logic                        w_sweep_end;
  logic                        w_advance;

  assign w_start     = (r_state == S_IDLE) && start_i && !stop_i;
  assign w_seg_end   = (r_dcnt == r_dwell_m1);
  assign w_sweep_end = w_seg_end && (r_scnt == r_len);
  // Phase only advances while the next sample will also be presented, so
  // phase_o holds its last value when the run ends or is aborted.
  assign w_advance   = (r_state == S_RUN) && (w_state_nxt == S_RUN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i && !stop_i) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_sweep_end && (r_len != '0) && !r_mode) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = 1'b0;
    phase_valid_o = 1'b0;
    sweep_done_o  = 1'b0;
    if (r_state == S_RUN) begin
      busy_o        = 1'b1;
      phase_valid_o = 1'b1;
      sweep_done_o  = w_sweep_end && (r_len != '0);
    end
  end

  assign phase_o = r_phase;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mode      <= 1'b0;
      r_ftw_start <= '0;
      r_ftw_step  <= '0;
      r_len       <= '0;
      r_dwell_m1  <= '0;
      r_ftw       <= '0;
      r_phase     <= '0;
      r_dcnt      <= '0;
      r_scnt      <= '0;
    end else if (w_start) begin
      r_mode      <= mode_i;
      r_ftw_start <= ftw_start_i;
      r_ftw_step  <= ftw_step_i;
      r_len       <= sweep_len_i;
      r_dwell_m1  <= (dwell_i == '0) ? '0 : dwell_i - 1'b1;
      r_ftw       <= ftw_start_i;
      r_phase     <= phase_off_i;
      r_dcnt      <= '0;
      r_scnt      <= '0;
    end else if (w_advance) begin
      r_phase <= r_phase + r_ftw;
      if (w_seg_end) begin
        r_dcnt <= '0;
        // Sweep boundary reloads the FTW but never touches the accumulator.
        if (r_scnt == r_len) begin
          r_scnt <= '0;
          r_ftw  <= r_ftw_start;
        end else begin
          r_scnt <= r_scnt + 1'b1;
          r_ftw  <= r_ftw + $unsigned(r_ftw_step);
        end
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: fixed vector table, hand-written control corners and
// randomized configurations checked against a closed-form phase model.
module tb_dds_phase_gen;
  localparam int PW = 25;
  localparam int CW = 16;

  typedef struct packed {
    logic          mode;
    logic [PW-1:0] ftw;
    logic [PW-1:0] step;
    logic [CW-1:0] len;
    logic [CW-1:0] dwell;
    logic [PW-1:0] off;
  } cfg_t;

  typedef struct packed {
    cfg_t                cfg;
    logic [7:0]          n;
    logic                ends;
    logic [11:0]         done_mask;
    logic [11:0][PW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, stop_i, mode_i;
  logic [PW-1:0] ftw_start_i, ftw_step_i, phase_off_i;
  logic [CW-1:0] sweep_len_i, dwell_i;
  logic [PW-1:0] phase_o;
  logic          phase_valid_o, busy_o, sweep_done_o;

  int total = 0;
  int bad   = 0;

  vec_t vecs [4];

  always #5 clk = ~clk;

  dds_phase_gen #(.PHASE_W(PW), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .mode_i       (mode_i),
    .ftw_start_i  (ftw_start_i),
    .ftw_step_i   (ftw_step_i),
    .sweep_len_i  (sweep_len_i),
    .dwell_i      (dwell_i),
    .phase_off_i  (phase_off_i),
    .phase_o      (phase_o),
    .phase_valid_o(phase_valid_o),
    .busy_o       (busy_o),
    .sweep_done_o (sweep_done_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Sample k = off + sum of per-sample FTWs, evaluated directly from the sweep rule.
  function automatic logic [PW-1:0] ref_phase(input cfg_t c, input int k);
    longint unsigned acc, d, period, s;
    d      = (c.dwell == 0) ? 64'd1 : longint'(c.dwell);
    period = (longint'(c.len) + 1) * d;
    acc    = longint'(c.off);
    for (int j = 0; j < k; j++) begin
      s   = longint'(j) % period;
      acc = acc + longint'(c.ftw) + (s / d) * longint'(c.step);
    end
    return acc[PW-1:0];
  endfunction

  function automatic logic ref_done(input cfg_t c, input int k);
    longint unsigned d, period;
    if (c.len == 0) return 1'b0;
    d      = (c.dwell == 0) ? 64'd1 : longint'(c.dwell);
    period = (longint'(c.len) + 1) * d;
    return (longint'(k) % period) == period - 1;
  endfunction

  function automatic int ref_period(input cfg_t c);
    int d;
    d = (c.dwell == 0) ? 1 : int'(c.dwell);
    return (int'(c.len) + 1) * d;
  endfunction

  // Issues a start at the current negedge; scrambles the inputs afterwards so
  // that any failure to latch them shows up in the sequence.
  task automatic launch(input cfg_t c);
    mode_i      = c.mode;
    ftw_start_i = c.ftw;
    ftw_step_i  = c.step;
    sweep_len_i = c.len;
    dwell_i     = c.dwell;
    phase_off_i = c.off;
    start_i     = 1'b1;
    stop_i      = 1'b0;
    @(negedge clk);
    start_i     = 1'b0;
    mode_i      = ~c.mode;
    ftw_start_i = PW'($urandom);
    ftw_step_i  = PW'($urandom);
    sweep_len_i = CW'($urandom);
    dwell_i     = CW'($urandom);
    phase_off_i = PW'($urandom);
  endtask

  task automatic run_check(input cfg_t c, input int nsamp, input bit do_stop, input string tag);
    launch(c);
    for (int k = 0; k < nsamp; k++) begin
      chk($sformatf("%s valid[%0d]", tag, k), phase_valid_o, 1'b1);
      chk($sformatf("%s phase[%0d]", tag, k), phase_o, ref_phase(c, k));
      chk($sformatf("%s done[%0d]", tag, k), sweep_done_o, ref_done(c, k));
      if (k < nsamp - 1) @(negedge clk);
    end
    if (do_stop) begin
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      chk({tag, " held phase"}, phase_o, ref_phase(c, nsamp - 1));
    end else begin
      @(negedge clk);
    end
    chk({tag, " end valid"}, phase_valid_o, 1'b0);
    chk({tag, " end busy"}, busy_o, 1'b0);
    chk({tag, " end done"}, sweep_done_o, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    cfg_t c;
    int   p, n;

    rst_n = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0;
    ftw_start_i = '0; ftw_step_i = '0; sweep_len_i = '0; dwell_i = '0; phase_off_i = '0;

    vecs[0] = '0;
    vecs[0].cfg = '{mode: 1'b0, ftw: 25'h100000, step: 25'h0, len: 16'd0, dwell: 16'd1, off: 25'h0};
    vecs[0].n = 8'd12;
    vecs[0].ends = 1'b0;
    for (int k = 0; k < 12; k++) vecs[0].exp[k] = PW'(k * 32'h100000);

    vecs[1] = '0;
    vecs[1].cfg = '{mode: 1'b0, ftw: 25'd10, step: 25'd5, len: 16'd2, dwell: 16'd2, off: 25'd3};
    vecs[1].n = 8'd6;
    vecs[1].ends = 1'b1;
    vecs[1].done_mask = 12'b0000_0010_0000;
    vecs[1].exp[0] = 25'd3;  vecs[1].exp[1] = 25'd13; vecs[1].exp[2] = 25'd23;
    vecs[1].exp[3] = 25'd38; vecs[1].exp[4] = 25'd53; vecs[1].exp[5] = 25'd73;

    vecs[2] = vecs[1];
    vecs[2].cfg.mode = 1'b1;
    vecs[2].n = 8'd12;
    vecs[2].ends = 1'b0;
    vecs[2].done_mask = 12'b1000_0010_0000;
    vecs[2].exp[6]  = 25'd93;  vecs[2].exp[7]  = 25'd103; vecs[2].exp[8]  = 25'd113;
    vecs[2].exp[9]  = 25'd128; vecs[2].exp[10] = 25'd143; vecs[2].exp[11] = 25'd163;

    vecs[3] = '0;
    vecs[3].cfg = '{mode: 1'b0, ftw: 25'h0, step: 25'h1FFFFFF, len: 16'd2, dwell: 16'd0, off: 25'h1FFFFFF};
    vecs[3].n = 8'd3;
    vecs[3].ends = 1'b1;
    vecs[3].done_mask = 12'b0000_0000_0100;
    vecs[3].exp[0] = 25'h1FFFFFF; vecs[3].exp[1] = 25'h1FFFFFF; vecs[3].exp[2] = 25'h1FFFFFE;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst phase", phase_o, '0);
    chk("rst valid", phase_valid_o, 1'b0);
    chk("rst busy", busy_o, 1'b0);
    chk("rst done", sweep_done_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after rst", busy_o, 1'b0);

    // Table vectors
    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].cfg);
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        chk($sformatf("vec%0d valid[%0d]", v, k), phase_valid_o, 1'b1);
        chk($sformatf("vec%0d busy[%0d]", v, k), busy_o, 1'b1);
        chk($sformatf("vec%0d phase[%0d]", v, k), phase_o, vecs[v].exp[k]);
        chk($sformatf("vec%0d done[%0d]", v, k), sweep_done_o, vecs[v].done_mask[k]);
        if (k < int'(vecs[v].n) - 1) @(negedge clk);
      end
      if (vecs[v].ends) begin
        @(negedge clk);
      end else begin
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        chk($sformatf("vec%0d held phase", v), phase_o, vecs[v].exp[int'(vecs[v].n) - 1]);
      end
      chk($sformatf("vec%0d end valid", v), phase_valid_o, 1'b0);
      chk($sformatf("vec%0d end busy", v), busy_o, 1'b0);
      chk($sformatf("vec%0d end done", v), sweep_done_o, 1'b0);
      @(negedge clk);
    end

    // Tone wraps to 0 on sample 32
    c = '{mode: 1'b1, ftw: 25'h100000, step: 25'h0, len: 16'd0, dwell: 16'd1, off: 25'h0};
    run_check(c, 34, 1'b1, "wrap");

    // Asynchronous reset mid-run, then stays idle
    c = vecs[2].cfg;
    launch(c);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst phase", phase_o, '0);
    chk("midrst valid", phase_valid_o, 1'b0);
    chk("midrst busy", busy_o, 1'b0);
    chk("midrst done", sweep_done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("postrst valid[%0d]", i), phase_valid_o, 1'b0);
      chk($sformatf("postrst busy[%0d]", i), busy_o, 1'b0);
    end

    // start and stop together in IDLE
    mode_i = 1'b1; ftw_start_i = 25'd7; ftw_step_i = 25'd1;
    sweep_len_i = 16'd1; dwell_i = 16'd1; phase_off_i = 25'd9;
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    chk("startstop busy", busy_o, 1'b0);
    chk("startstop valid", phase_valid_o, 1'b0);
    @(negedge clk);
    chk("startstop busy2", busy_o, 1'b0);

    // start pulsed mid-sweep is ignored
    c = vecs[2].cfg;
    launch(c);
    for (int k = 0; k < 12; k++) begin
      start_i = (k == 2);
      chk($sformatf("restart phase[%0d]", k), phase_o, ref_phase(c, k));
      chk($sformatf("restart done[%0d]", k), sweep_done_o, ref_done(c, k));
      @(negedge clk);
    end
    start_i = 1'b0;
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("restart stop valid", phase_valid_o, 1'b0);
    @(negedge clk);

    // stop on the sweep-end cycle in continuous mode
    launch(c);
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("endstop phase", phase_o, 25'd73);
    chk("endstop done", sweep_done_o, 1'b1);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("endstop valid", phase_valid_o, 1'b0);
    chk("endstop busy", busy_o, 1'b0);
    chk("endstop done after", sweep_done_o, 1'b0);
    @(negedge clk);

    // Randomized configurations
    for (int r = 0; r < 25; r++) begin
      c.mode  = 1'($urandom);
      c.ftw   = PW'($urandom);
      c.step  = PW'($urandom);
      c.len   = CW'($urandom_range(0, 4));
      c.dwell = CW'($urandom_range(0, 3));
      c.off   = PW'($urandom);
      p = ref_period(c);
      if (!c.mode && c.len != 0 && $urandom_range(0, 1) == 1) begin
        run_check(c, p, 1'b0, $sformatf("rnd%0d", r));
      end else begin
        n = (!c.mode && c.len != 0) ? $urandom_range(1, p) : $urandom_range(1, 30);
        run_check(c, n, 1'b1, $sformatf("rnd%0d", r));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_phase_gen.md
Name: dds_phase_gen

Overview:
- Phase-sequence generator directly upstream of the DDS core (dds_ii_0).
- Drives the core's phase_i/phase_valid_i with a phase accumulator: constant tone or a stepped linear frequency sweep (chirp), single-shot or continuous.
- Configuration is latched at start, so the sweep runs autonomously and is observable on the on-chip analyzer.

Parameters:
- PHASE_W, 25, width of phase accumulator, tuning words and phase output (matches DDS core phase_i).
- CNT_W, 16, width of sweep-length and dwell counters.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  start request, sampled each clk_i edge.
- stop_i  input  1  abort request, sampled each edge.
- mode_i  input  1  0 = single sweep, 1 = continuous (repeat sweep).
- ftw_start_i  input  PHASE_W  initial frequency tuning word.
- ftw_step_i  input  PHASE_W  signed two's-complement FTW increment per segment.
- sweep_len_i  input  CNT_W  number of FTW increments; 0 = constant tone.
- dwell_i  input  CNT_W  samples per frequency segment; 0 treated as 1.
- phase_off_i  input  PHASE_W  constant phase offset added to output.
- phase_o  output  PHASE_W  phase word to DDS phase_i.
- phase_valid_o  output  1  qualifies phase_o; drives DDS phase_valid_i.
- busy_o  output  1  high while in RUN.
- sweep_done_o  output  1  one-cycle pulse on last sample of each sweep.

Behaviour:
- Reset: asynchronous, active-low. All state clears while rst_n_i is low: state=IDLE, phase_o=0, phase_valid_o=0, busy_o=0, sweep_done_o=0, accumulator and counters 0.
- States: IDLE, RUN.
- Start (IDLE, start_i=1, stop_i=0):
  - Latch mode, ftw_start, ftw_step, sweep_len, dwell (0 -> 1) and phase_off.
  - Go to RUN.
  - Next cycle: first valid sample, phase_o=phase_off.
- Sample sequence in RUN (one sample per cycle, no backpressure):
  - Sample k = (off + sum_{j<k} f_j) mod 2^PHASE_W.
  - f_j = ftw_start + floor(s/dwell)*ftw_step mod 2^PHASE_W, where s = j mod ((sweep_len+1)*dwell).
  - All arithmetic wraps modulo 2^PHASE_W; the step is sign-extended.
- Registered output: phase_o/phase_valid_o update on the clock edge. Latency from the start_i edge to the first valid sample is 1 cycle.
- Sweep end (sample index (sweep_len+1)*dwell-1 within a sweep):
  - sweep_done_o=1 on that same cycle.
  - mode 0: next cycle state=IDLE, phase_valid_o=0, busy_o=0.
  - mode 1: FTW reloads to ftw_start. The accumulator continues without reset (phase-continuous). Repeats indefinitely.
- sweep_len=0: constant tone until stop_i, in either mode; sweep_done_o never pulses.
- stop_i in RUN: next cycle IDLE, phase_valid_o=0, busy_o=0, no sweep_done_o. phase_o holds its last value.
- stop_i and start_i in the same cycle: stop wins, so the block stays in or returns to IDLE.
- start_i while in RUN: ignored. Inputs changing in RUN: ignored until the next start.
- Reset asserted mid-sweep: immediate return to reset values. No output activity until a new start_i after release.
- Counters: dwell counter 0..dwell-1, segment counter 0..sweep_len. Both reset at each sweep boundary and on start.

Test Plan:
- Reset: rst_n_i low mid-RUN -> phase_o=0, phase_valid_o=0, busy_o=0, sweep_done_o=0 immediately. After release, stays idle with start_i low.
- Constant tone: ftw_start=0x100000, step=0, sweep_len=0, dwell=1, off=0 -> phase_o 0x000000, 0x100000, 0x200000 ... 0x1F00000, then wraps to 0 on sample 32. stop_i -> phase_valid_o=0 the next cycle, no sweep_done_o.
- Single sweep: ftw_start=10, step=5, sweep_len=2, dwell=2, off=3, mode=0 -> valid samples 3, 13, 23, 38, 53, 73. sweep_done_o on sample 73. Then valid=0, busy=0.
- Continuous: same config, mode=1 -> samples 3, 13, 23, 38, 53, 73, 93, 103, 113, 128 ... sweep_done_o on samples 6 and 12 (indices 5, 11).
- Negative step and dwell=0: ftw_start=0, step=0x1FFFFFF, sweep_len=2, dwell=0, off=0x1FFFFFF, mode=0 -> samples 0x1FFFFFF, 0x1FFFFFF, 0x1FFFFFE. Done pulse on the third sample.
- Control corners: start_i and stop_i together in IDLE -> stays IDLE. start_i pulsed mid-sweep -> sequence unchanged. stop_i on the same cycle as the sweep end in mode 1 -> IDLE next cycle, sweep_done_o still high that cycle.
